// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time over a valid/ready
// channel, waits a configurable number of cycles, then performs the access
// and returns a single-cycle response pulse (or an error pulse right away).
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        RespError
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   counter_q, counter_d;
    logic            reqWrite_q, reqWrite_d;
    logic [1:0]      reqSize_q, reqSize_d;
    logic            reqSigned_q, reqSigned_d;
    logic [AW+1:0]   reqAddr_q, reqAddr_d;
    logic [31:0]     writeData_q, writeData_d;
    logic [31:0]     readData_q, readData_d;
    logic            respError_q, respError_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            reqError;
    logic            memWe;
    logic [3:0]      byteEn;
    logic [31:0]     memWData;
    logic [31:0]     loadWord;
    logic [7:0]      selByte;
    logic [15:0]     selHalf;
    logic [31:0]     loadValue;

    assign ReqReady  = (state_q == IDLE) && !Reset;
    assign RespValid = (state_q == RESP);
    assign ReadData  = readData_q;
    assign RespError = respError_q;

    // Classify an incoming request as rejected from the raw request fields
    always_comb begin
        reqError = 1'b0;
        case (ReqSize)
            2'b01:   reqError = Address[0];
            2'b10:   reqError = |Address[1:0];
            2'b11:   reqError = 1'b1;
            default: reqError = 1'b0;
        endcase
        if ({1'b0, Address} >= ByteLimit) begin
            reqError = 1'b1;
        end
    end

    // Select the addressed lanes of the stored word and extend them for loads
    always_comb begin
        loadWord = mem[reqAddr_q[AW+1:2]];
        case (reqAddr_q[1:0])
            2'd0:    selByte = loadWord[7:0];
            2'd1:    selByte = loadWord[15:8];
            2'd2:    selByte = loadWord[23:16];
            default: selByte = loadWord[31:24];
        endcase
        selHalf = reqAddr_q[1] ? loadWord[31:16] : loadWord[15:0];
        case (reqSize_q)
            2'b00:   loadValue = {{24{reqSigned_q & selByte[7]}}, selByte};
            2'b01:   loadValue = {{16{reqSigned_q & selHalf[15]}}, selHalf};
            2'b10:   loadValue = loadWord;
            default: loadValue = 32'd0;
        endcase
    end

    // Byte-lane enables and lane-replicated store data for the memory write
    always_comb begin
        case (reqSize_q)
            2'b00:   byteEn = 4'b0001 << reqAddr_q[1:0];
            2'b01:   byteEn = reqAddr_q[1] ? 4'b1100 : 4'b0011;
            2'b10:   byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
        case (reqSize_q)
            2'b00:   memWData = {4{writeData_q[7:0]}};
            2'b01:   memWData = {2{writeData_q[15:0]}};
            default: memWData = writeData_q;
        endcase
        memWe = (state_q == WAIT) && (counter_q == '0) && reqWrite_q && !Reset;
    end

    // Next-state logic for the IDLE/WAIT/RESP request sequencer
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        reqWrite_d  = reqWrite_q;
        reqSize_d   = reqSize_q;
        reqSigned_d = reqSigned_q;
        reqAddr_d   = reqAddr_q;
        writeData_d = writeData_q;
        readData_d  = readData_q;
        respError_d = respError_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    reqWrite_d  = ReqWrite;
                    reqSize_d   = ReqSize;
                    reqSigned_d = ReqSigned;
                    reqAddr_d   = Address[AW+1:0];
                    writeData_d = WriteData;
                    if (reqError) begin
                        state_d     = RESP;
                        respError_d = 1'b1;
                        readData_d  = 32'd0;
                    end else begin
                        state_d   = WAIT;
                        counter_d = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (counter_q != '0) begin
                    counter_d = counter_q - CW'(1);
                end else begin
                    state_d     = RESP;
                    respError_d = 1'b0;
                    readData_d  = reqWrite_q ? 32'd0 : loadValue;
                end
            end
            RESP: begin
                state_d     = IDLE;
                readData_d  = 32'd0;
                respError_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and latched-request registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            reqWrite_q  <= 1'b0;
            reqSize_q   <= 2'b00;
            reqSigned_q <= 1'b0;
            reqAddr_q   <= '0;
            writeData_q <= 32'd0;
            readData_q  <= 32'd0;
            respError_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            reqWrite_q  <= reqWrite_d;
            reqSize_q   <= reqSize_d;
            reqSigned_q <= reqSigned_d;
            reqAddr_q   <= reqAddr_d;
            writeData_q <= writeData_d;
            readData_q  <= readData_d;
            respError_q <= respError_d;
        end
    end

    // Memory array keeps its contents across reset; only enabled lanes change
    always_ff @(posedge Clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[reqAddr_q[AW+1:2]][i*8 +: 8] <= memWData[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: each accepted request pushes its
// expected response onto a scoreboard queue, which is popped on RespValid.
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        RespError;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbQueue[$];
    int   total = 0;
    int   bad   = 0;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqWrite (ReqWrite),
        .ReqSize  (ReqSize),
        .ReqSigned(ReqSigned),
        .Address  (Address),
        .WriteData(WriteData),
        .RespValid(RespValid),
        .ReadData (ReadData),
        .RespError(RespError)
    );

    // Free-running clock, 10 time units per period
    always #5 Clk = ~Clk;

    // Global guard so a stuck design can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and every failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after an accept edge: waits for the response, compares it
    // with the scoreboard head and checks the return to IDLE one edge later.
    // Edge count is the number of edges after the accept edge; errored
    // requests enter RESP on the accept edge itself, so they count as 0.
    task automatic waitResponse(input string tag);
        int   edges;
        int   readySeen;
        exp_t e;
        edges     = 0;
        readySeen = 0;
        while (!RespValid && edges < 20) begin
            if (ReqReady) readySeen++;
            @(posedge Clk);
            #1;
            edges++;
        end
        checkOutput({tag, "_ready_low_wait"}, 32'(readySeen), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(RespValid), 32'd1);
        checkOutput({tag, "_sb_pending"}, 32'(sbQueue.size()), 32'd1);
        if (RespValid && sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput({tag, "_latency"}, 32'(edges), 32'(e.lat));
            checkOutput({tag, "_data"}, ReadData, e.data);
            checkOutput({tag, "_err"}, 32'(RespError), 32'(e.err));
            checkOutput({tag, "_ready_low_resp"}, 32'(ReqReady), 32'd0);
        end
        @(posedge Clk);
        #1;
        checkOutput({tag, "_pulse_end"}, 32'(RespValid), 32'd0);
        checkOutput({tag, "_data_clr"}, ReadData, 32'd0);
        checkOutput({tag, "_err_clr"}, 32'(RespError), 32'd0);
        checkOutput({tag, "_ready_idle"}, 32'(ReqReady), 32'd1);
    endtask

    // Drive one request, wait for acceptance, record its expected response
    task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input int expLat);
        int   waits;
        exp_t e;
        @(negedge Clk);
        ReqValid  = 1'b1;
        ReqWrite  = wr;
        ReqSize   = sz;
        ReqSigned = sgn;
        Address   = addr;
        WriteData = wdata;
        waits     = 0;
        while (!ReqReady && waits < 50) begin
            @(negedge Clk);
            waits++;
        end
        checkOutput({tag, "_accept"}, 32'(ReqReady), 32'd1);
        if (!ReqReady) begin
            ReqValid = 1'b0;
            return;
        end
        @(posedge Clk);
        e.data = expData;
        e.err  = expErr;
        e.lat  = expLat;
        sbQueue.push_back(e);
        #1;
        ReqValid = 1'b0;
        waitResponse(tag);
    endtask

    initial begin
        Reset     = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqSize   = 2'b00;
        ReqSigned = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge Clk);
            checkOutput("rst_ready", 32'(ReqReady), 32'd0);
        end
        checkOutput("rst_valid", 32'(RespValid), 32'd0);
        checkOutput("rst_data", ReadData, 32'd0);
        checkOutput("rst_err", 32'(RespError), 32'd0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("post_rst_ready", 32'(ReqReady), 32'd1);
        checkOutput("post_rst_valid", 32'(RespValid), 32'd0);

        // Word store and load back
        applyStimulus("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, LATENCY);
        applyStimulus("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, LATENCY);

        // Byte store into lane 1 only, then loads of several widths
        applyStimulus("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA80, 32'h0, 1'b0, LATENCY);
        applyStimulus("ld_sb11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, LATENCY);
        applyStimulus("ld_ub11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000080, 1'b0, LATENCY);
        applyStimulus("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0, LATENCY);
        applyStimulus("ld_sh12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, LATENCY);
        applyStimulus("ld_uh10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h000080EF, 1'b0, LATENCY);

        // Halfword store into the upper lanes of a known word
        applyStimulus("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h01234567, 32'h0, 1'b0, LATENCY);
        applyStimulus("st_h22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h9999CAFE, 32'h0, 1'b0, LATENCY);

        // Rejected requests respond immediately and leave memory alone
        applyStimulus("err_h13", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("err_w22", 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        applyStimulus("err_rsv", 1'b1, 2'b11, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b1, 0);
        applyStimulus("err_oor", 1'b0, 2'b10, 1'b0, 32'(DEPTH_WORDS * 4), 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("ld_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFE4567, 1'b0, LATENCY);
        applyStimulus("ld_ub23", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h000000CA, 1'b0, LATENCY);

        // Back-to-back: ReqValid stays high, second request waits for IDLE
        @(negedge Clk);
        ReqValid  = 1'b1;
        ReqWrite  = 1'b0;
        ReqSize   = 2'b10;
        ReqSigned = 1'b0;
        Address   = 32'h10;
        checkOutput("b2b_a_accept", 32'(ReqReady), 32'd1);
        @(posedge Clk);
        sbQueue.push_back('{data: 32'hDEAD80EF, err: 1'b0, lat: LATENCY});
        #1;
        ReqSize   = 2'b00;
        Address   = 32'h13;
        waitResponse("b2b_a");
        checkOutput("b2b_b_pending", 32'(ReqValid), 32'd1);
        @(posedge Clk);
        sbQueue.push_back('{data: 32'h000000DE, err: 1'b0, lat: LATENCY});
        #1;
        ReqValid = 1'b0;
        waitResponse("b2b_b");

        // Reset in WAIT, on the cycle just before the store would land
        applyStimulus("st_w40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, 32'h0, 1'b0, LATENCY);
        @(negedge Clk);
        ReqValid  = 1'b1;
        ReqWrite  = 1'b1;
        ReqSize   = 2'b10;
        Address   = 32'h40;
        WriteData = 32'h12345678;
        checkOutput("abort_accept", 32'(ReqReady), 32'd1);
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (3) begin
            @(posedge Clk);
            #1;
            checkOutput("abort_no_resp", 32'(RespValid), 32'd0);
            checkOutput("abort_ready", 32'(ReqReady), 32'd0);
        end
        Reset = 1'b0;
        applyStimulus("ld_w40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, LATENCY);

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
